payout_judge: RTL and testbench

PAYOUT_JUDGE -- requirements
Module: payout_judge

---
 rtl/payout_judge_pkg.sv | 31 +++
 rtl/payout_judge_payout_table.sv | 52 +++++
 rtl/payout_judge.sv | 136 +++++++++++++
 tb/tb_payout_judge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/payout_judge_pkg.sv
// payout_judge_pkg: definitions shared by the payout_judge slice.
//   - state_e : FSM encodings (IDLE=0, READY=1, SPIN=2, PAY=3)
//   - DEF_*   : default bet, credit ceiling and award amounts
//   - bin_to_bcd : 0..99 binary to two-digit BCD (tens:ones)
// Optional feature macro used by this slice: JACKPOT_SEVEN_EN.
package payout_judge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SPIN  = 2'd2,
    PAY   = 2'd3
  } state_e;

  localparam int DEF_BET         = 1;
  localparam int DEF_MAX_CREDIT  = 99;
  localparam int DEF_PAIR_PAY    = 2;
  localparam int DEF_TRIPLE_PAY  = 10;
  localparam int DEF_JACKPOT_PAY = 50;

  // Tens digit found by threshold compares; ones is the remainder.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
    logic [3:0] tens;
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (value >= 7'(i * 10)) tens = 4'(i);
    end
    return {tens, 4'(value - 7'(tens) * 7'd10)};
  endfunction

endpackage

// File: rtl/payout_judge_payout_table.sv
// payout_table: combinational award lookup for three BCD reel digits.
//   reel1..reel3 : BCD digits
//   award        : TRIPLE_PAY for three equal, PAIR_PAY for exactly two
//                  equal, 0 otherwise or when any digit is above 9.
// Macro JACKPOT_SEVEN_EN: triple 7 pays JACKPOT_PAY instead of TRIPLE_PAY.
module payout_table
  import payout_judge_pkg::*;
#(
  parameter int PAIR_PAY   = DEF_PAIR_PAY,
  parameter int TRIPLE_PAY = DEF_TRIPLE_PAY
`ifdef JACKPOT_SEVEN_EN
  , parameter int JACKPOT_PAY = DEF_JACKPOT_PAY
`endif
) (
  input  logic [3:0] reel1,
  input  logic [3:0] reel2,
  input  logic [3:0] reel3,
  output logic [6:0] award
);

  logic [2:0][3:0] digits;
  logic [2:0]      digit_bad;
  logic            eq12, eq13, eq23;

  assign digits = {reel3, reel2, reel1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit_chk
      assign digit_bad[gi] = (digits[gi] > 4'd9);
    end
  endgenerate

  assign eq12 = (reel1 == reel2);
  assign eq13 = (reel1 == reel3);
  assign eq23 = (reel2 == reel3);

  always_comb begin
    award = 7'd0;
    if (digit_bad == 3'b000) begin
      if (eq12 && eq13) begin
`ifdef JACKPOT_SEVEN_EN
        award = (reel1 == 4'd7) ? 7'(JACKPOT_PAY) : 7'(TRIPLE_PAY);
`else
        award = 7'(TRIPLE_PAY);
`endif
      end else if (eq12 || eq13 || eq23) begin
        award = 7'(PAIR_PAY);
      end
    end
  end

endmodule

// File: rtl/payout_judge.sv
// payout_judge: slot-machine credit FSM (IDLE/READY/SPIN/PAY).
//   CLK, RST          : clock, synchronous active-high reset
//   COIN_IN, START    : one-cycle coin and game-start pulses
//   REEL_DONE, REEL1..3 : reel-stop pulse with BCD digits
//   CREDIT, CREDIT_BCD : credit in binary and tens:ones BCD
//   GAME_OK           : pulse when a start is accepted and the bet taken
//   WIN, PAYOUT       : last game's win flag and award
//   STATE             : FSM state code
// Macro JACKPOT_SEVEN_EN: enables the triple-7 jackpot award (JACKPOT_PAY).
module payout_judge
  import payout_judge_pkg::*;
#(
  parameter int BET        = DEF_BET,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int PAIR_PAY   = DEF_PAIR_PAY,
  parameter int TRIPLE_PAY = DEF_TRIPLE_PAY
`ifdef JACKPOT_SEVEN_EN
  , parameter int JACKPOT_PAY = DEF_JACKPOT_PAY
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       COIN_IN,
  input  logic       START,
  input  logic       REEL_DONE,
  input  logic [3:0] REEL1,
  input  logic [3:0] REEL2,
  input  logic [3:0] REEL3,
  output logic [6:0] CREDIT,
  output logic [7:0] CREDIT_BCD,
  output logic       GAME_OK,
  output logic       WIN,
  output logic [6:0] PAYOUT,
  output logic [1:0] STATE
);

  localparam logic [7:0] BET_W = 8'(BET);
  localparam logic [7:0] MAX_W = 8'(MAX_CREDIT);

  state_e          state_q, state_d;
  logic [6:0]      credit_q, credit_d;
  logic [2:0][3:0] reels_q, reels_d;
  logic            payout_vld_q, payout_vld_d;
  logic            win_q, win_d;
  logic            game_ok_q, game_ok_d;
  logic [7:0]      sum;
  logic [6:0]      award;

  function automatic logic [6:0] sat(input logic [7:0] v);
    return (v > MAX_W) ? 7'(MAX_W) : v[6:0];
  endfunction

  // The award is always derived from the latched reels; the valid flag
  // keeps PAYOUT at 0 until a game has actually finished since reset.
  payout_table #(
    .PAIR_PAY   (PAIR_PAY),
    .TRIPLE_PAY (TRIPLE_PAY)
`ifdef JACKPOT_SEVEN_EN
    , .JACKPOT_PAY(JACKPOT_PAY)
`endif
  ) u_payout_table (
    .reel1 (reels_q[0]),
    .reel2 (reels_q[1]),
    .reel3 (reels_q[2]),
    .award (award)
  );

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    reels_d      = reels_q;
    payout_vld_d = payout_vld_q;
    win_d        = win_q;
    game_ok_d    = 1'b0;
    sum          = {1'b0, credit_q} + {7'd0, COIN_IN};
    case (state_q)
      IDLE: begin
        if (COIN_IN) begin
          credit_d = 7'd1;
          state_d  = READY;
        end
      end
      READY: begin
        // Coin and bet in the same cycle combine before saturation.
        if (START && ({1'b0, credit_q} >= BET_W)) begin
          sum       = sum - BET_W;
          game_ok_d = 1'b1;
          win_d     = 1'b0;
          state_d   = SPIN;
        end
        credit_d = sat(sum);
      end
      SPIN: begin
        credit_d = sat(sum);
        if (REEL_DONE) begin
          reels_d      = {REEL3, REEL2, REEL1};
          payout_vld_d = 1'b1;
          state_d      = PAY;
        end
      end
      PAY: begin
        sum      = sum + {1'b0, award};
        credit_d = sat(sum);
        win_d    = (award != 7'd0);
        state_d  = (credit_d != 7'd0) ? READY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      credit_q     <= 7'd0;
      reels_q      <= '0;
      payout_vld_q <= 1'b0;
      win_q        <= 1'b0;
      game_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      reels_q      <= reels_d;
      payout_vld_q <= payout_vld_d;
      win_q        <= win_d;
      game_ok_q    <= game_ok_d;
    end
  end

  assign CREDIT     = credit_q;
  assign CREDIT_BCD = bin_to_bcd(credit_q);
  assign GAME_OK    = game_ok_q;
  assign WIN        = win_q;
  assign PAYOUT     = payout_vld_q ? award : 7'd0;
  assign STATE      = state_q;

endmodule

// File: tb/tb_payout_judge.sv
module tb_payout_judge;

  localparam int BET = 1;
  localparam int MAX_CREDIT = 99;
`ifdef JACKPOT_SEVEN_EN
  localparam int SEVENS_PAY = 50;
`else
  localparam int SEVENS_PAY = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       COIN_IN = 1'b0;
  logic       START = 1'b0;
  logic       REEL_DONE = 1'b0;
  logic [3:0] REEL1 = 4'd0;
  logic [3:0] REEL2 = 4'd0;
  logic [3:0] REEL3 = 4'd0;
  logic [6:0] CREDIT;
  logic [7:0] CREDIT_BCD;
  logic       GAME_OK;
  logic       WIN;
  logic [6:0] PAYOUT;
  logic [1:0] STATE;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (0=IDLE,1=READY,2=SPIN,3=PAY)
  int m_state = 0, m_credit = 0, m_payout = 0, m_win = 0, m_gok = 0;

  payout_judge dut (
    .CLK(CLK), .RST(RST), .COIN_IN(COIN_IN), .START(START),
    .REEL_DONE(REEL_DONE), .REEL1(REEL1), .REEL2(REEL2), .REEL3(REEL3),
    .CREDIT(CREDIT), .CREDIT_BCD(CREDIT_BCD), .GAME_OK(GAME_OK),
    .WIN(WIN), .PAYOUT(PAYOUT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pay(input int a, input int b, input int c);
    int n;
    if (a > 9 || b > 9 || c > 9) return 0;
    n = int'(a == b) + int'(b == c) + int'(a == c);
    if (n == 3) return (a == 7) ? SEVENS_PAY : 10;
    if (n == 1) return 2;
    return 0;
  endfunction

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic step(input bit rst, input bit coin, input bit start, input bit done,
                      input int a, input int b, input int c);
    int nc;
    RST = rst; COIN_IN = coin; START = start; REEL_DONE = done;
    REEL1 = 4'(a); REEL2 = 4'(b); REEL3 = 4'(c);
    @(posedge CLK);
    if (rst) begin
      m_state = 0; m_credit = 0; m_payout = 0; m_win = 0; m_gok = 0;
    end else begin
      m_gok = 0;
      case (m_state)
        0: if (coin) begin m_credit = 1; m_state = 1; end
        1: begin
          nc = m_credit + int'(coin);
          if (start && m_credit >= BET) begin
            nc -= BET; m_gok = 1; m_win = 0; m_state = 2;
          end
          m_credit = min_i(nc, MAX_CREDIT);
        end
        2: begin
          m_credit = min_i(m_credit + int'(coin), MAX_CREDIT);
          if (done) begin
            m_payout = ref_pay(a, b, c);
            m_state = 3;
            $display("game reels=%0d,%0d,%0d payout=%0d", a, b, c, m_payout);
          end
        end
        default: begin
          m_credit = min_i(MAX_CREDIT, m_credit + m_payout + int'(coin));
          m_win = int'(m_payout != 0);
          m_state = (m_credit > 0) ? 1 : 0;
        end
      endcase
    end
    #1;
    check("state", int'(STATE), m_state);
    check("credit", int'(CREDIT), m_credit);
    check("credit_bcd", int'(CREDIT_BCD), (m_credit / 10) * 16 + (m_credit % 10));
    check("game_ok", int'(GAME_OK), m_gok);
    check("win", int'(WIN), m_win);
    check("payout", int'(PAYOUT), m_payout);
  endtask

  task automatic idle();      step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic coin();      step(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_reset();  step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic spin_done(input int a, input int b, input int c);
    step(0, 0, 0, 1, a, b, c);
  endtask

  initial begin
    bit rs, cn, st, dn;
    int a, b, c;

    // Reset and three coins
    do_reset();
    check("rst_state", int'(STATE), 0);
    check("rst_credit", int'(CREDIT), 0);
    repeat (3) coin();
    check("coin3_credit", int'(CREDIT), 3);
    check("coin3_bcd", int'(CREDIT_BCD), 8'h03);
    check("coin3_state", int'(STATE), 1);
    $display("scenario coins: credit=%0d", CREDIT);

    // Triple 4 win
    step(0, 0, 1, 0, 0, 0, 0);
    check("start_gok", int'(GAME_OK), 1);
    check("start_credit", int'(CREDIT), 2);
    spin_done(4, 4, 4);
    check("t444_payout", int'(PAYOUT), 10);
    idle();
    check("t444_credit", int'(CREDIT), 12);
    check("t444_win", int'(WIN), 1);
    check("t444_state", int'(STATE), 1);

    // Last credit lost
    do_reset(); coin();
    step(0, 0, 1, 0, 0, 0, 0);
    spin_done(1, 2, 3);
    idle();
    check("lose_credit", int'(CREDIT), 0);
    check("lose_state", int'(STATE), 0);
    check("lose_win", int'(WIN), 0);
    $display("scenario lose: state=%0d", STATE);

    // Saturation with coin in PAY
    do_reset();
    repeat (95) coin();
    check("c95_credit", int'(CREDIT), 95);
    step(0, 0, 1, 0, 0, 0, 0);
    spin_done(5, 5, 5);
    step(0, 1, 0, 0, 0, 0, 0);
    check("sat_credit", int'(CREDIT), 99);
    check("sat_bcd", int'(CREDIT_BCD), 8'h99);
    $display("scenario saturate: credit=%0d", CREDIT);

    // Coin and start together, then triple 7
    do_reset(); coin();
    step(0, 1, 1, 0, 0, 0, 0);
    check("cs_credit", int'(CREDIT), 1);
    check("cs_gok", int'(GAME_OK), 1);
    spin_done(7, 7, 7);
    check("t777_payout", int'(PAYOUT), SEVENS_PAY);
    idle();
    $display("scenario sevens: payout=%0d credit=%0d", PAYOUT, CREDIT);

    // Reset mid-spin, later REEL_DONE ignored
    do_reset(); coin(); coin();
    step(0, 0, 1, 0, 0, 0, 0);
    do_reset();
    check("rspin_state", int'(STATE), 0);
    check("rspin_credit", int'(CREDIT), 0);
    check("rspin_win", int'(WIN), 0);
    spin_done(1, 1, 1);
    check("rspin_ign_state", int'(STATE), 0);
    check("rspin_ign_payout", int'(PAYOUT), 0);
    $display("scenario reset-in-spin: state=%0d", STATE);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 149) == 0);
      cn = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 3) == 0);
      dn = (m_state == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      a = int'($urandom_range(0, 11));
      b = ($urandom_range(0, 2) == 0) ? a : int'($urandom_range(0, 11));
      c = ($urandom_range(0, 2) == 0) ? a : int'($urandom_range(0, 11));
      step(rs, cn, st, dn, a, b, c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
